// File: rtl/paddle_ctl.sv
// paddle_ctl: debounced up/down button pair to clamped paddle position,
// with press step, hold auto-repeat and a release lockout.
module paddle_ctl #(
  parameter int HOLD_FIRST  = 32767,
  parameter int HOLD_REPEAT = 4095,
  parameter int DEB_TIME    = 16383,
  parameter int STEP        = 4,
  parameter int YMIN        = 0,
  parameter int YMAX        = 400,
  parameter int YINIT       = 200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       freeze,
  input  logic       center,
  output logic [9:0] ypos,
  output logic       moved,
  output logic       dir,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, FIRST, REPEAT, LOCK} state_t;
  state_t      st;
  logic [15:0] cnt;
  logic [1:0]  up_q, dn_q;
  logic        hdir, up_s, dn_s, held, opp, step, sdir;
  logic [10:0] dn_y;
  logic [9:0]  up_y, ny;
  assign up_s = ~up_q[1];
  assign dn_s = ~dn_q[1];
  always_comb begin
    held = hdir ? dn_s : up_s;
    opp  = hdir ? up_s : dn_s;
    step = (st == IDLE) ? (up_s ^ dn_s) :
           ((st == FIRST || st == REPEAT) && held && !opp && cnt == 16'd0);
    sdir = (st == IDLE) ? dn_s : hdir;
    dn_y = {1'b0, ypos} + 11'(STEP);
    // up step is clamped before subtracting so it can never wrap below zero
    up_y = ({1'b0, ypos} < 11'(YMIN + STEP)) ? 10'(YMIN) : ypos - 10'(STEP);
    ny   = sdir ? ((dn_y > 11'(YMAX)) ? 10'(YMAX) : dn_y[9:0]) : up_y;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_q  <= 2'b11;
      dn_q  <= 2'b11;
      st    <= IDLE;
      cnt   <= 16'd0;
      hdir  <= 1'b0;
      busy  <= 1'b0;
      ypos  <= 10'(YINIT);
      moved <= 1'b0;
      dir   <= 1'b0;
    end else begin
      up_q <= {up_q[0], btn_up};
      dn_q <= {dn_q[0], btn_dn};
      case (st)
        IDLE:
          if (up_s ^ dn_s) begin
            st   <= FIRST;
            hdir <= dn_s;
            cnt  <= 16'(HOLD_FIRST);
            busy <= 1'b1;
          end
        FIRST, REPEAT:
          if (!held || opp) begin
            st  <= LOCK;
            cnt <= 16'(DEB_TIME);
          end else if (cnt == 16'd0) begin
            st  <= REPEAT;
            cnt <= 16'(HOLD_REPEAT);
          end else cnt <= cnt - 16'd1;
        default:
          if (cnt == 16'd0) begin
            st   <= IDLE;
            busy <= 1'b0;
          end else cnt <= cnt - 16'd1;
      endcase
      if (step) dir <= sdir;
      if (center) begin
        ypos  <= 10'(YINIT);
        moved <= 1'b0;
      end else if (step && !freeze) begin
        ypos  <= ny;
        moved <= ny != ypos;
      end else moved <= 1'b0;
    end
  end
endmodule

// File: tb/tb_paddle_ctl.sv
// tb_paddle_ctl: directed scenarios with cycle-tagged expectations checked by a monitor.
module tb_paddle_ctl;
  logic       clk = 1'b0;
  logic       reset_n, btn_up, btn_dn, freeze, center;
  logic [9:0] ypos;
  logic       moved, dir, busy;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int k;
  typedef struct {
    int   c;
    int   y;
    bit   m;
    bit   d;
    bit   b;
  } exp_t;
  exp_t q[$];

  paddle_ctl #(
    .HOLD_FIRST(7), .HOLD_REPEAT(3), .DEB_TIME(5), .STEP(4),
    .YMIN(8), .YMAX(40), .YINIT(24)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_up(btn_up), .btn_dn(btn_dn),
    .freeze(freeze), .center(center), .ypos(ypos), .moved(moved),
    .dir(dir), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // expectation tagged with the edge after which it must hold
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.c < cyc) begin
        failures++;
        $display("FAIL missed@%0d at cyc=%0d", e.c, cyc);
      end else if (ypos != 10'(e.y) || moved != e.m || dir != e.d || busy != e.b) begin
        failures++;
        $display("FAIL out@%0d got y=%0d m=%0b d=%0b b=%0b exp y=%0d m=%0b d=%0b b=%0b",
                 e.c, ypos, moved, dir, busy, e.y, e.m, e.d, e.b);
      end
    end
  end

  task automatic ex(input int c, input int y, input bit m, input bit d, input bit b);
    exp_t e;
    e.c = c; e.y = y; e.m = m; e.d = d; e.b = b;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic recentre(input bit d);
    int t;
    t = cyc + 1;
    center = 1'b1;
    ex(t, 24, 0, d, 0);
    wait_cyc(t);
    center = 1'b0;
    wait_cyc(t + 2);
  endtask

  initial begin
    reset_n = 1'b0; btn_up = 1'b1; btn_dn = 1'b1; freeze = 1'b0; center = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 10; i++) ex(cyc + i, 24, 0, 0, 0);
    wait_cyc(cyc + 12);
    // single tap down
    btn_dn = 1'b0; k = cyc + 1;
    ex(k+1, 24, 0, 0, 0); ex(k+2, 28, 1, 1, 1); ex(k+3, 28, 0, 1, 1);
    ex(k+8, 28, 0, 1, 1); ex(k+9, 28, 0, 1, 0);
    wait_cyc(k); btn_dn = 1'b1;
    wait_cyc(k+14);
    recentre(1);
    // hold down, clamp at top, release coinciding with a due step
    btn_dn = 1'b0; k = cyc + 1;
    ex(k+2, 28, 1, 1, 1); ex(k+3, 28, 0, 1, 1); ex(k+9, 28, 0, 1, 1);
    ex(k+10, 32, 1, 1, 1); ex(k+14, 36, 1, 1, 1); ex(k+18, 40, 1, 1, 1);
    ex(k+19, 40, 0, 1, 1); ex(k+22, 40, 0, 1, 1); ex(k+42, 40, 0, 1, 1);
    ex(k+47, 40, 0, 1, 1); ex(k+48, 40, 0, 1, 0);
    wait_cyc(k+39); btn_dn = 1'b1;
    wait_cyc(k+52);
    // both pressed from idle
    btn_up = 1'b0; btn_dn = 1'b0; k = cyc + 1;
    ex(k+2, 40, 0, 1, 0); ex(k+3, 40, 0, 1, 0); ex(k+6, 40, 0, 1, 0); ex(k+9, 40, 0, 1, 0);
    wait_cyc(k+5); btn_up = 1'b1; btn_dn = 1'b1;
    wait_cyc(k+10);
    recentre(1);
    // up held, down joins during FIRST
    btn_up = 1'b0; k = cyc + 1;
    ex(k+2, 20, 1, 0, 1); ex(k+5, 20, 0, 0, 1); ex(k+6, 20, 0, 0, 1);
    ex(k+11, 20, 0, 0, 1); ex(k+12, 20, 0, 0, 0); ex(k+20, 20, 0, 0, 0);
    wait_cyc(k+3); btn_dn = 1'b0;
    wait_cyc(k+20); btn_up = 1'b1; btn_dn = 1'b1;
    wait_cyc(k+26);
    recentre(0);
    // frozen hold
    freeze = 1'b1; btn_up = 1'b0; k = cyc + 1;
    ex(k+2, 24, 0, 0, 1); ex(k+10, 24, 0, 0, 1); ex(k+18, 24, 0, 0, 1);
    ex(k+27, 24, 0, 0, 1); ex(k+28, 24, 0, 0, 0);
    wait_cyc(k+19); btn_up = 1'b1;
    wait_cyc(k+30); freeze = 1'b0;
    // centre on the same edge as a repeat step
    btn_up = 1'b0; k = cyc + 1;
    ex(k+2, 20, 1, 0, 1); ex(k+10, 16, 1, 0, 1); ex(k+14, 24, 0, 0, 1);
    ex(k+18, 20, 1, 0, 1); ex(k+28, 20, 0, 0, 0);
    wait_cyc(k+13); center = 1'b1;
    wait_cyc(k+14); center = 1'b0;
    wait_cyc(k+19); btn_up = 1'b1;
    wait_cyc(k+30);
    recentre(0);
    // asynchronous reset in REPEAT with the button still held
    btn_up = 1'b0; k = cyc + 1;
    ex(k+14, 12, 1, 0, 1); ex(k+15, 24, 0, 0, 0); ex(k+16, 24, 0, 0, 0);
    ex(k+18, 24, 0, 0, 0); ex(k+19, 20, 1, 0, 1); ex(k+28, 20, 0, 0, 0);
    wait_cyc(k+14);
    @(posedge clk); #1 reset_n = 1'b0;
    wait_cyc(k+16); #1 reset_n = 1'b1;
    wait_cyc(k+19); btn_up = 1'b1;
    wait_cyc(k+30);
    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    while (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL pending@%0d never reached", q[0].c);
      void'(q.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/paddle_ctl.md
# paddle_ctl

Player paddle controller for the table-tennis game. It converts one player's pair of active-low up/down buttons into a clamped vertical paddle position. It provides a single immediate step on press, auto-repeat after a hold delay, and a release lockout that absorbs contact bounce. One instance per player sits between the board button pins and the ball/paddle renderer, which consumes `ypos`.

## Interface

Parameters:
- `HOLD_FIRST`, 32767 — cycles between the press step and the first auto-repeat step, minus one; must be ≤ 65535.
- `HOLD_REPEAT`, 4095 — auto-repeat period minus one, in cycles; must be ≤ 65535.
- `DEB_TIME`, 16383 — release lockout length minus one, in cycles; must be ≤ 65535.
- `STEP`, 4 — pixels moved per step; range 1..63.
- `YMIN`, 0 — lowest allowed `ypos`.
- `YMAX`, 400 — highest allowed `ypos`; must be ≤ 1023 and ≥ `YMIN`.
- `YINIT`, 200 — reset and recentre position; `YMIN` ≤ `YINIT` ≤ `YMAX`.

Ports:
- `clk` input 1 — master clock; all state changes on its rising edge.
- `reset_n` input 1 — asynchronous, active-low reset.
- `btn_up` input 1 — active-low up button; asynchronous to `clk`.
- `btn_dn` input 1 — active-low down button; asynchronous to `clk`.
- `freeze` input 1 — while high, steps are suppressed.
- `center` input 1 — synchronous pulse; sets `ypos` to `YINIT`.
- `ypos` output 10 — paddle top position; registered.
- `moved` output 1 — one-cycle strobe when `ypos` changed due to a step; registered.
- `dir` output 1 — direction of the last applied step, 1 = down (increasing y); registered.
- `busy` output 1 — high when the FSM is not IDLE.

## Operation

- **Input synchronisation:** `btn_up` and `btn_dn` each pass through a 2-flop synchroniser and are inverted, giving `up_s` and `dn_s` (1 = pressed).
- **Counter:** one shared 16-bit down-counter `cnt`.
- **FSM states:** IDLE, FIRST, REPEAT, LOCK.
  - **IDLE**
    - Exactly one of `up_s`/`dn_s` set: issue a step in that direction, latch it as the held direction, load `cnt` with `HOLD_FIRST`, go to FIRST.
    - Both set or neither set: stay in IDLE. No step is issued.
  - **FIRST / REPEAT**
    - Held button released, or the opposite button pressed: load `DEB_TIME`, go to LOCK. This takes priority over a step.
    - Else if `cnt == 0`: issue a step, load `HOLD_REPEAT`, go to (or stay in) REPEAT.
    - Else: decrement `cnt`.
  - **LOCK**
    - Inputs are ignored.
    - `cnt == 0`: go to IDLE.
    - Else: decrement `cnt`.
- **Step arithmetic:** computed 11 bits wide to avoid wrap.
  - Down: `min(ypos + STEP, YMAX)`.
  - Up: `max(ypos - STEP, YMIN)`; the subtraction is signed or checked, so it never underflows.
- **Step application:**
  - A step with `freeze` high leaves `ypos` unchanged and keeps `moved` at 0. The FSM and counter still advance.
  - `dir` updates on every issued step, even when the step is frozen or clamped.
  - `moved` is 1 only when the new `ypos` differs from the old one. A clamped step has `moved` = 0.
- **Recentre:** `center` high sets `ypos` to `YINIT` and forces `moved` to 0. It overrides any same-cycle step. The FSM is unaffected.
- **Reset values:** `ypos` = `YINIT`, `moved` = 0, `dir` = 0, `busy` = 0, state = IDLE, `cnt` = 0, synchroniser flops = 1 (released).
- **Reset mid-operation:** asserting `reset_n` in any state returns everything to the reset values immediately (asynchronously).

## Timing

- Button first sampled low at edge k: `up_s`/`dn_s` valid after edge k+1. The step lands in `ypos` at edge k+2, and `moved` is high for the cycle following edge k+2.
- First repeat step occurs at edge k+2+`HOLD_FIRST`+1. Subsequent steps follow every `HOLD_REPEAT`+1 cycles.
- Release seen at synchronised edge r: enter LOCK at edge r. IDLE is re-entered at edge r+`DEB_TIME`+1.
- A new press can step no earlier than one edge after IDLE is re-entered.
- `center` sampled at edge c gives `ypos` = `YINIT` after edge c.
- `busy` is registered from the state: high from the FIRST entry edge through the edge returning to IDLE.

## Test plan

Common parameters: `HOLD_FIRST`=7, `HOLD_REPEAT`=3, `DEB_TIME`=5, `STEP`=4, `YMIN`=8, `YMAX`=40, `YINIT`=24.

- **Reset:** pulse `reset_n` low, release, idle 10 cycles -> `ypos`=24, `moved`=0, `dir`=0, `busy`=0 throughout.
- **Single tap:** `btn_dn` low for one sample at edge k -> `ypos`=28 at k+2; `moved` high for one cycle; `dir`=1; `busy` falls at k+9 (FIRST, then LOCK for 6 cycles).
- **Hold down, clamp at top:** `btn_dn` held 40 cycles from edge k -> `ypos` 28@k+2, 32@k+10, 36@k+14, 40@k+18; then stays 40 with `moved`=0 on later steps.
- **Conflicting buttons:**
  - Both buttons pressed from IDLE -> no step.
  - `btn_up` held, then `btn_dn` pressed during FIRST -> one up step (`ypos`=20), then LOCK, with no further steps until both are released and lockout completes.
- **Freeze and recentre:**
  - `freeze` high while `btn_up` is held 20 cycles -> `ypos` stays 24, `moved`=0, `dir`=0.
  - `center` asserted on the same edge as a repeat step (`ypos` 16 -> 12) -> `ypos`=24, `moved`=0.
- **Reset mid-repeat:** `btn_up` held, assert `reset_n` low in REPEAT (`ypos`=12) -> `ypos`=24 and `busy`=0 immediately. After release with the button still held, the first step appears 2 edges after the first sampled press.
